// File: rtl/clock_divider_bank.sv
// Bank of independent 50%-duty clock dividers. Half-period changes are staged
// through a ready/valid port and only take effect at a period boundary.
module clock_divider_bank #(
  parameter int                      NUM_CH       = 2,
  parameter int                      CNT_W        = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_HALF = {CNT_W'(1_000_000), CNT_W'(100_000_000)},
  parameter int                      CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  cnt_r   [NUM_CH];
  logic [CNT_W-1:0]  half_r  [NUM_CH];
  logic [CNT_W-1:0]  stage_r [NUM_CH];
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] clk_out_r;
  logic [NUM_CH-1:0] tick_r;

  logic [CNT_W-1:0]  cnt_s   [NUM_CH];
  logic [CNT_W-1:0]  half_s  [NUM_CH];
  logic [CNT_W-1:0]  stage_s [NUM_CH];
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] clk_out_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] term_s;
  logic [NUM_CH-1:0] apply_s;
  logic [CNT_W-1:0]  cfg_half_s;

  // Channel decode and back-pressure; an out-of-range channel selects nothing and is always ready.
  always_comb begin
    sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = (cfg_ch == CH_W'(i));
    end
    cfg_ready  = ~|(sel_s & pend_r);
    cfg_half_s = (cfg_half == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_half;
  end

  // Per-channel next state: sync beats terminal count beats plain counting.
  always_comb begin
    term_s    = {NUM_CH{1'b0}};
    apply_s   = {NUM_CH{1'b0}};
    pend_s    = pend_r;
    clk_out_s = clk_out_r;
    tick_s    = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_s[i]   = cnt_r[i];
      half_s[i]  = half_r[i];
      stage_s[i] = stage_r[i];
      term_s[i]  = enable[i] && (cnt_r[i] == half_r[i] - CNT_W'(1));
      apply_s[i] = pend_r[i] && (sync || term_s[i] || !enable[i]);

      if (sync) begin
        cnt_s[i]     = {CNT_W{1'b0}};
        clk_out_s[i] = 1'b0;
      end else if (term_s[i]) begin
        cnt_s[i]     = {CNT_W{1'b0}};
        clk_out_s[i] = ~clk_out_r[i];
        tick_s[i]    = 1'b1;
      end else if (enable[i]) begin
        cnt_s[i] = cnt_r[i] + CNT_W'(1);
      end else if (apply_s[i] && (cnt_r[i] >= stage_r[i])) begin
        // A shorter half applied while stopped would leave the held count past terminal.
        cnt_s[i] = stage_r[i] - CNT_W'(1);
      end else begin
        cnt_s[i] = cnt_r[i];
      end

      if (apply_s[i]) begin
        half_s[i] = stage_r[i];
        pend_s[i] = 1'b0;
      end else begin
        half_s[i] = half_r[i];
      end

      // A transfer needs pend clear, so it never collides with an apply on the same channel.
      if (cfg_valid && sel_s[i] && !pend_r[i]) begin
        stage_s[i] = cfg_half_s;
        pend_s[i]  = 1'b1;
      end else begin
        stage_s[i] = stage_r[i];
      end
    end
  end

  // State registers with asynchronous reset to the default half-periods.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]   <= {CNT_W{1'b0}};
        half_r[i]  <= DEFAULT_HALF[i*CNT_W +: CNT_W];
        stage_r[i] <= {CNT_W{1'b0}};
      end
      pend_r    <= {NUM_CH{1'b0}};
      clk_out_r <= {NUM_CH{1'b0}};
      tick_r    <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]   <= cnt_s[i];
        half_r[i]  <= half_s[i];
        stage_r[i] <= stage_s[i];
      end
      pend_r    <= pend_s;
      clk_out_r <= clk_out_s;
      tick_r    <= tick_s;
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: a spec-level channel model queues the
// expected clk_out/tick per edge; directed checks cover the called-out scenarios.
module tb_clock_divider_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int CH_W   = 2;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] enable;
  logic              sync;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_cnt   [NUM_CH];
  int         m_half  [NUM_CH];
  int         m_stage [NUM_CH];
  bit [1:0]   m_pend;
  bit [1:0]   m_clk;
  bit [1:0]   m_tick;
  logic [3:0] exp_q[$];

  clock_divider_bank #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF ({4'd1, 4'd3}),
    .CH_W         (CH_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i]   = 0;
      m_stage[i] = 0;
    end
    m_half[0] = 3;
    m_half[1] = 1;
    m_pend    = 2'b00;
    m_clk     = 2'b00;
    m_tick    = 2'b00;
  endfunction

  function automatic void model_edge();
    bit tc;
    bit xfer;
    bit app;
    for (int i = 0; i < NUM_CH; i++) begin
      tc   = enable[i] && (m_cnt[i] == m_half[i] - 1);
      xfer = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
      app  = m_pend[i] && (sync || tc || !enable[i]);
      m_tick[i] = !sync && tc;
      if (sync) begin
        m_cnt[i] = 0;
        m_clk[i] = 1'b0;
      end else if (tc) begin
        m_cnt[i] = 0;
        m_clk[i] = !m_clk[i];
      end else if (enable[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (app) begin
        m_half[i] = m_stage[i];
        m_pend[i] = 1'b0;
      end
      if (xfer) begin
        m_stage[i] = (cfg_half == 4'd0) ? 1 : int'(cfg_half);
        m_pend[i]  = 1'b1;
      end
    end
  endfunction

  // One clock: check cfg_ready, queue the model's outputs, compare after the edge.
  task automatic step();
    logic [3:0] exp_v;
    logic [3:0] got_v;
    logic       exp_rdy;
    int         c;
    @(negedge clk);
    c = int'(cfg_ch);
    if (c < NUM_CH) exp_rdy = !m_pend[c];
    else            exp_rdy = 1'b1;
    n_checks++;
    if (cfg_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL sb_cfg_ready t=%0t got %b exp %b", $time, cfg_ready, exp_rdy);
    end
    model_edge();
    exp_q.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    got_v = {clk_out, tick};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL sb_outputs t=%0t {clk_out,tick} got %b exp %b", $time, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (clk_out !== 2'b00) begin n_fail++; $display("FAIL reset_clk_out got %b exp %b", clk_out, 2'b00); end
    n_checks++;
    if (tick !== 2'b00) begin n_fail++; $display("FAIL reset_tick got %b exp %b", tick, 2'b00); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b exp %b", cfg_ready, 1'b1); end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_default_run();
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    enable = 2'b11;
    repeat (12) begin
      step();
      n0 += int'(tick[0]);
      n1 += int'(tick[1]);
    end
    n_checks++;
    if (n0 != 4) begin n_fail++; $display("FAIL default_tick0_count got %0d exp %0d", n0, 4); end
    n_checks++;
    if (n1 != 12) begin n_fail++; $display("FAIL default_tick1_count got %0d exp %0d", n1, 12); end
    n_checks++;
    if (clk_out !== 2'b00) begin n_fail++; $display("FAIL default_clk_out got %b exp %b", clk_out, 2'b00); end
  endtask

  task automatic test_enable_hold();
    step();
    enable = 2'b10;
    repeat (5) begin
      step();
      n_checks++;
      if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL hold_tick0 got %b exp %b", tick[0], 1'b0); end
      n_checks++;
      if (clk_out[0] !== 1'b0) begin n_fail++; $display("FAIL hold_clk_out0 got %b exp %b", clk_out[0], 1'b0); end
    end
    enable = 2'b11;
    step();
    n_checks++;
    if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL resume_tick0_early got %b exp %b", tick[0], 1'b0); end
    step();
    n_checks++;
    if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL resume_tick0 got %b exp %b", tick[0], 1'b1); end
    repeat (4) step();
  endtask

  task automatic test_cfg_stage();
    int n0;
    for (int k = 0; k < 10 && m_cnt[0] != 1; k++) step();
    n_checks++;
    if (m_cnt[0] != 1) begin n_fail++; $display("FAIL stage_setup_cnt0 got %0d exp %0d", m_cnt[0], 1); end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 4'd5;
    step();
    cfg_valid = 1'b0;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stage_ready_pending got %b exp %b", cfg_ready, 1'b0); end
    step();
    n_checks++;
    if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL stage_old_half_tick got %b exp %b", tick[0], 1'b1); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL stage_ready_after_apply got %b exp %b", cfg_ready, 1'b1); end
    n0 = 0;
    repeat (4) begin
      step();
      n0 += int'(tick[0]);
    end
    n_checks++;
    if (n0 != 0) begin n_fail++; $display("FAIL stage_new_half_quiet got %0d exp %0d", n0, 0); end
    step();
    n_checks++;
    if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL stage_new_half_tick got %b exp %b", tick[0], 1'b1); end
    repeat (5) step();
  endtask

  task automatic test_cfg_clamp();
    int n1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_half  = 4'd3;
    step();
    cfg_valid = 1'b0;
    repeat (6) step();
    cfg_valid = 1'b1;
    cfg_half  = 4'd0;
    step();
    cfg_valid = 1'b0;
    repeat (6) step();
    n1 = 0;
    repeat (3) begin
      step();
      n1 += int'(tick[1]);
    end
    n_checks++;
    if (n1 != 3) begin n_fail++; $display("FAIL clamp_tick1_count got %0d exp %0d", n1, 3); end
    cfg_ch   = 2'd3;
    cfg_half = 4'd7;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ch_ready got %b exp %b", cfg_ready, 1'b1); end
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ch_ready_after got %b exp %b", cfg_ready, 1'b1); end
    repeat (4) step();
  endtask

  task automatic test_sync();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 4'd2;
    step();
    sync     = 1'b1;
    cfg_ch   = 2'd1;
    cfg_half = 4'd2;
    step();
    sync      = 1'b0;
    cfg_valid = 1'b0;
    n_checks++;
    if (clk_out !== 2'b00) begin n_fail++; $display("FAIL sync_clk_out got %b exp %b", clk_out, 2'b00); end
    n_checks++;
    if (tick !== 2'b00) begin n_fail++; $display("FAIL sync_tick got %b exp %b", tick, 2'b00); end
    step();
    n_checks++;
    if (tick !== 2'b10) begin n_fail++; $display("FAIL sync_edge1_tick got %b exp %b", tick, 2'b10); end
    step();
    n_checks++;
    if (tick !== 2'b01) begin n_fail++; $display("FAIL sync_edge2_tick got %b exp %b", tick, 2'b01); end
    repeat (4) step();
  endtask

  task automatic test_reset_pending();
    int n0;
    int n1;
    step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 4'd4;
    step();
    cfg_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (clk_out !== 2'b00) begin n_fail++; $display("FAIL async_reset_clk_out got %b exp %b", clk_out, 2'b00); end
    n_checks++;
    if (tick !== 2'b00) begin n_fail++; $display("FAIL async_reset_tick got %b exp %b", tick, 2'b00); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready got %b exp %b", cfg_ready, 1'b1); end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
    n0 = 0;
    n1 = 0;
    repeat (6) begin
      step();
      n0 += int'(tick[0]);
      n1 += int'(tick[1]);
    end
    n_checks++;
    if (n0 != 2) begin n_fail++; $display("FAIL reset_restore_tick0 got %0d exp %0d", n0, 2); end
    n_checks++;
    if (n1 != 6) begin n_fail++; $display("FAIL reset_restore_tick1 got %0d exp %0d", n1, 6); end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 2'b00;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_half  = 4'd0;
    model_reset();
    test_reset();
    test_default_run();
    test_enable_hold();
    test_cfg_stage();
    test_cfg_clamp();
    test_sync();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
